// File: rtl/ob_tx_serializer_pkg.sv
// Shared types and helpers for the output-buffer serializer.
// Latency: n/a (package only).
// Backpressure: n/a. Frame length grows by one bit under OB_TX_SERIALIZER_PARITY_EN.
package ob_tx_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      WARM  = 2'd1,
      IDLE  = 2'd2,
      SHIFT = 2'd3
   } ob_state_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // Bit-times per serialized word, including the optional parity bit.
   function automatic int FRAME_LEN(input int width);
`ifdef OB_TX_SERIALIZER_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/ob_tx_serializer_shiftreg.sv
// Load/shift register plus bit counter for one serial frame (LSB first).
// Latency: next_bit_o is combinational; state updates on the rising clock edge.
// Backpressure: none; the parent decides when to load or shift.
module ob_tx_shiftreg
   import ob_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             next_bit_o,
   output logic             last_o
);

   localparam int FL = FRAME_LEN(WIDTH);
   localparam int RW = FL - 1;
   localparam int CW = clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);

   logic [FL-1:0] frame;
   logic [RW-1:0] sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;

`ifdef OB_TX_SERIALIZER_PARITY_EN
   assign frame = {^din_i, din_i};
`else
   assign frame = din_i;
`endif

   // The register holds only the bits still to be shown after the current one,
   // so the bit for the next bit-time is always at index 0 (or frame[0] on load).
   assign next_bit_o = load_i ? frame[0] : sr_q[0];
   assign last_o     = (cnt_q == LAST_CNT);

   // Next-state: load a fresh frame, or advance one bit-time.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         sr_d  = frame[FL-1:1];
         cnt_d = '0;
      end else if (shift_i) begin
         sr_d  = sr_q >> 1;
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ob_tx_serializer.sv
// Serializes WIDTH-bit words onto one pad bit with registered tristate and output-enable guard interval.
// Latency: word accepted on edge t shows DIN[0] on Q after edge t; back-to-back words are gapless.
// Backpressure: DRDY high only in IDLE or the last bit-time with OE=1. Parity bit: OB_TX_SERIALIZER_PARITY_EN.
module ob_tx_serializer
   import ob_tx_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   GUARD      = 4,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             OE,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DVAL,
   output logic             DRDY,
   output logic             Q,
   output logic             TS,
   output logic             BUSY
);

   localparam int GW = clog2(GUARD + 1);
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

   ob_state_e     state_q;
   logic [GW-1:0] gcnt_q;
   logic          q_q, ts_q, busy_q;
   logic          last_bit, next_bit, xfer, sr_shift;

   assign DRDY     = OE && ((state_q == IDLE) || ((state_q == SHIFT) && last_bit));
   assign xfer     = DRDY && DVAL;
   assign sr_shift = (state_q == SHIFT) && !last_bit;

   ob_tx_shiftreg #(.WIDTH(WIDTH)) u_sr (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (xfer),
      .shift_i    (sr_shift),
      .din_i      (DIN),
      .next_bit_o (next_bit),
      .last_o     (last_bit)
   );

   // Pad FSM: tristate release, guard interval, word acceptance and frame completion.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= OFF;
         gcnt_q  <= '0;
         q_q     <= IDLE_LEVEL;
         ts_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            OFF: begin
               q_q    <= IDLE_LEVEL;
               busy_q <= 1'b0;
               gcnt_q <= '0;
               if (OE) begin
                  state_q <= WARM;
                  ts_q    <= 1'b0;
               end else begin
                  ts_q    <= 1'b1;
               end
            end
            WARM: begin
               if (!OE) begin
                  state_q <= OFF;
                  ts_q    <= 1'b1;
                  gcnt_q  <= '0;
               end else if (gcnt_q == GUARD_LAST) begin
                  state_q <= IDLE;
                  gcnt_q  <= '0;
               end else begin
                  gcnt_q  <= gcnt_q + 1'b1;
               end
            end
            IDLE: begin
               if (xfer) begin
                  state_q <= SHIFT;
                  q_q     <= next_bit;
                  busy_q  <= 1'b1;
               end else if (!OE) begin
                  state_q <= OFF;
                  ts_q    <= 1'b1;
               end
            end
            SHIFT: begin
               // A dropped OE never truncates a word; it only takes effect after the last bit-time.
               if (!last_bit || xfer) begin
                  q_q <= next_bit;
               end else begin
                  q_q     <= IDLE_LEVEL;
                  busy_q  <= 1'b0;
                  state_q <= OE ? IDLE : OFF;
                  ts_q    <= !OE;
               end
            end
            default: state_q <= OFF;
         endcase
      end
   end

   assign Q    = q_q;
   assign TS   = ts_q;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_ob_tx_serializer.sv
// Self-checking bench for ob_tx_serializer: vector table, directed corner sequences, randomized stream vs queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ob_tx_serializer;

   localparam int   WIDTH      = 8;
   localparam int   GUARD      = 4;
   localparam logic IDLE_LEVEL = 1'b1;
`ifdef OB_TX_SERIALIZER_PARITY_EN
   localparam int   FL         = WIDTH + 1;
`else
   localparam int   FL         = WIDTH;
`endif

   logic             CLK = 1'b0;
   logic             RST, OE, DVAL;
   logic [WIDTH-1:0] DIN;
   logic             DRDY, Q, TS, BUSY;

   int n_cmp = 0;
   int n_bad = 0;

   ob_tx_serializer #(.WIDTH(WIDTH), .GUARD(GUARD), .IDLE_LEVEL(IDLE_LEVEL)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .OE   (OE),
      .DIN  (DIN),
      .DVAL (DVAL),
      .DRDY (DRDY),
      .Q    (Q),
      .TS   (TS),
      .BUSY (BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst;
      logic       oe;
      logic       dval;
      logic [7:0] din;
      logic       q;
      logic       ts;
      logic       drdy;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic oe, input logic dval, input logic [7:0] din,
                      input logic q, input logic ts, input logic drdy, input logic busy);
      vec_t v;
      v.rst = rst; v.oe = oe; v.dval = dval; v.din = din;
      v.q = q; v.ts = ts; v.drdy = drdy; v.busy = busy;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic act, input logic want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b required %b", nm, $time, act, want);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input logic rst, input logic oe, input logic dval, input logic [7:0] din);
      @(negedge CLK);
      RST = rst; OE = oe; DVAL = dval; DIN = din;
      #1;
   endtask

   task automatic expect4(input string nm, input logic q, input logic ts, input logic drdy, input logic busy);
      chk({nm, ".Q"},    Q,    q);
      chk({nm, ".TS"},   TS,   ts);
      chk({nm, ".DRDY"}, DRDY, drdy);
      chk({nm, ".BUSY"}, BUSY, busy);
   endtask

   // Bit k of the serialized frame of word w: data LSB first, then even parity.
   function automatic logic frame_bit(input logic [7:0] w, input int k);
      if (k < WIDTH) return w[k];
      return ^w;
   endfunction

   // From OFF: one OFF cycle with OE=1, GUARD driven-idle cycles, then ready in IDLE.
   task automatic guard_seq(input string nm);
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      expect4({nm, "-off"}, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < GUARD; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         expect4({nm, "-warm"}, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      expect4({nm, "-ready"}, 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   // From IDLE: send words back-to-back, offering each next word only in the last bit-time.
   task automatic send_words(input string nm, input logic [7:0] w[$]);
      logic       last;
      logic       more;
      logic [7:0] nxt;
      drive(1'b0, 1'b1, 1'b1, w[0]);
      expect4({nm, "-load"}, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < w.size(); j++) begin
         for (int k = 0; k < FL; k++) begin
            last = (k == FL - 1);
            more = last && (j + 1 < w.size());
            nxt  = 8'h00;
            if (more) nxt = w[j + 1];
            drive(1'b0, 1'b1, more, nxt);
            expect4({nm, "-bit"}, frame_bit(w[j], k), 1'b0, last, 1'b1);
         end
      end
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      expect4({nm, "-idle"}, 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   logic [7:0] wq[$];
   logic       cur_m, busy_m, drdy_m, dv, oe_now;
   logic [7:0] d;
   logic       pend[$];

   initial begin
      RST = 1'b1; OE = 1'b1; DVAL = 1'b1; DIN = 8'hFF;
      @(posedge CLK);

      // Reset held with OE/DVAL high, release, guard, then 8'hA5 with ignored DVAL mid-word.
      for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < GUARD; i++) add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef OB_TX_SERIALIZER_PARITY_EN
      add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
`else
      add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
`endif
      add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].oe, tbl[i].dval, tbl[i].din);
         expect4($sformatf("vec%0d", i), tbl[i].q, tbl[i].ts, tbl[i].drdy, tbl[i].busy);
      end

      // Gapless pair 0F then F0.
      wq.delete(); wq.push_back(8'h0F); wq.push_back(8'hF0);
      send_words("gapless", wq);

      // OE dropped during bit 3 of 8'h3C: word completes, DRDY stays low, then OFF.
      drive(1'b0, 1'b1, 1'b1, 8'h3C);
      expect4("oedrop-load", 1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < FL; k++) begin
         oe_now = (k < 3);
         drive(1'b0, oe_now, 1'b1, 8'hFF);
         expect4($sformatf("oedrop-bit%0d", k), frame_bit(8'h3C, k), 1'b0, 1'b0, 1'b1);
      end
      drive(1'b0, 1'b0, 1'b1, 8'hFF);
      expect4("oedrop-off", 1'b1, 1'b1, 1'b0, 1'b0);
      guard_seq("reoe");

      // Reset during bit 5 of 8'h5A (bit5 = 0): discarded, then full guard again.
      drive(1'b0, 1'b1, 1'b1, 8'h5A);
      expect4("rst-load", 1'b1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00);
         expect4($sformatf("rst-bit%0d", k), frame_bit(8'h5A, k), 1'b0, 1'b0, 1'b1);
      end
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      expect4("rst-bit5", 1'b0, 1'b0, 1'b0, 1'b1);
      guard_seq("postrst");

`ifdef OB_TX_SERIALIZER_PARITY_EN
      wq.delete(); wq.push_back(8'h07);
      send_words("par07", wq);
      wq.delete(); wq.push_back(8'h03);
      send_words("par03", wq);
`endif

      // Randomized stream with OE held high, against a bit-queue model.
      cur_m  = IDLE_LEVEL;
      busy_m = 1'b0;
      pend.delete();
      for (int c = 0; c < 400; c++) begin
         dv = ($urandom_range(0, 3) != 0);
         d  = 8'($urandom);
         drive(1'b0, 1'b1, dv, d);
         drdy_m = (pend.size() == 0);
         expect4("rand", cur_m, 1'b0, drdy_m, busy_m);
         if (drdy_m && dv)
            for (int k = 0; k < FL; k++) pend.push_back(frame_bit(d, k));
         if (pend.size() > 0) begin
            cur_m  = pend.pop_front();
            busy_m = 1'b1;
         end else begin
            cur_m  = IDLE_LEVEL;
            busy_m = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
